alu_src_arbiter: RTL and testbench

ALU_SRC_ARBITER -- requirements
Module: alu_src_arbiter

---
 rtl/alu_src_arbiter_pkg.sv | 18 +
 rtl/alu_src_arbiter_rr_arb2.sv | 36 +++
 rtl/alu_src_arbiter.sv | 117 +++++++++++
 tb/tb_alu_src_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_src_arbiter_pkg.sv
// Shared definitions for the ALU operand-source arbiter.
//   arb_state_e   : arbitration FSM states (ARB, LOCK_A, LOCK_B)
//   SEL_A / SEL_B : Selector / grant encodings for requester A and B
//   DEFAULT_WIDTH : default operand width
package alu_src_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_src_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant with lock override.
// Ports:
//   valid_a, valid_b : requester valids
//   last_grant       : requester granted at the most recent transfer
//   hold_grant       : grant of the previous cycle, kept when nobody is valid
//   state            : arbitration FSM state; LOCK_x pins the grant to x
//   grant            : SEL_A or SEL_B
module rr_arb2
  import alu_src_arbiter_pkg::*;
(
  input  logic       valid_a,
  input  logic       valid_b,
  input  logic       last_grant,
  input  logic       hold_grant,
  input  arb_state_e state,
  output logic       grant
);

  always_comb begin
    grant = hold_grant;
    case (state)
      LOCK_A: grant = SEL_A;
      LOCK_B: grant = SEL_B;
      default: begin
        if (valid_a && valid_b) begin
          grant = ~last_grant;
        end else if (valid_a) begin
          grant = SEL_A;
        end else if (valid_b) begin
          grant = SEL_B;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_src_arbiter.sv
// alu_src_arbiter: arbitrates two operand requesters onto one registered ALU
// operand port (valid/ready on both sides, latency 1, 1 operand/cycle).
// Optional feature macro: ALU_SRC_ARBITER_LOCK_EN enables grant retention via
// Lock_a/Lock_b; when undefined the lock inputs are ignored (pure round robin).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   Valid_x, Data_x, Ready_x, Lock_x : requester x (x = a, b) handshake + lock
//   Selector                         : operand mux select (0 = A, 1 = B)
//   Out_valid, Out_data, Out_ready   : registered operand towards the ALU
module alu_src_arbiter
  import alu_src_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid_a,
  input  logic [WIDTH-1:0] Data_a,
  output logic             Ready_a,
  input  logic             Lock_a,
  input  logic             Valid_b,
  input  logic [WIDTH-1:0] Data_b,
  output logic             Ready_b,
  input  logic             Lock_b,
  output logic             Selector,
  output logic             Out_valid,
  output logic [WIDTH-1:0] Out_data,
  input  logic             Out_ready
);

  arb_state_e       state_q, state_d;
  logic             last_q;
  logic             sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             grant;
  logic             can_accept;
  logic             xfer_a, xfer_b;

  rr_arb2 u_rr_arb2 (
    .valid_a    (Valid_a),
    .valid_b    (Valid_b),
    .last_grant (last_q),
    .hold_grant (sel_q),
    .state      (state_q),
    .grant      (grant)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
`ifdef ALU_SRC_ARBITER_LOCK_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (xfer_a && Lock_a) begin
          state_d = LOCK_A;
        end else if (xfer_b && Lock_b) begin
          state_d = LOCK_B;
        end
      end
      // Leaving on !Valid && !Lock keeps an idle lock holder from starving the other side.
      LOCK_A: if (!Lock_a && (xfer_a || !Valid_a)) state_d = ARB;
      LOCK_B: if (!Lock_b && (xfer_b || !Valid_b)) state_d = ARB;
      default: state_d = ARB;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = Lock_a ^ Lock_b;

  always_comb begin
    state_d = ARB;
  end
`endif

  // Output logic; handshakes and Selector are held inactive during reset
  always_comb begin
    can_accept = !out_valid_q || Out_ready;
    Ready_a    = rst_n && (grant == SEL_A) && Valid_a && can_accept;
    Ready_b    = rst_n && (grant == SEL_B) && Valid_b && can_accept;
    Selector   = rst_n ? grant : SEL_A;
    xfer_a     = Valid_a && Ready_a;
    xfer_b     = Valid_b && Ready_b;
  end

  // Output operand register, round-robin pointer and held grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= SEL_B;
      sel_q       <= SEL_A;
    end else begin
      sel_q <= grant;
      if (xfer_a || xfer_b) begin
        out_valid_q <= 1'b1;
        out_data_q  <= (grant == SEL_B) ? Data_b : Data_a;
        last_q      <= grant;
      end else if (Out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;

endmodule

// File: tb/tb_alu_src_arbiter.sv
// Self-checking bench for alu_src_arbiter: directed stimulus, expected output
// operands queued by the stimulus and checked by an independent monitor.
module tb_alu_src_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Valid_a, Valid_b, Lock_a, Lock_b, Out_ready;
  logic [5:0] Data_a, Data_b;
  logic       Ready_a, Ready_b, Selector, Out_valid;
  logic [5:0] Out_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] exp_q[$];

  alu_src_arbiter #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Valid_a   (Valid_a),
    .Data_a    (Data_a),
    .Ready_a   (Ready_a),
    .Lock_a    (Lock_a),
    .Valid_b   (Valid_b),
    .Data_b    (Data_b),
    .Ready_b   (Ready_b),
    .Lock_b    (Lock_b),
    .Selector  (Selector),
    .Out_valid (Out_valid),
    .Out_data  (Out_data),
    .Out_ready (Out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the next queued operand.
  always @(negedge clk) begin
    if (rst_n && Out_valid && Out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got %0h, required no output", Out_data);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (Out_data !== e) begin
          n_bad++;
          $display("FAIL out_data: got %0h, required %0h", Out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    {Valid_a, Valid_b, Lock_a, Lock_b, Out_ready} = '0;
    Data_a = '0;
    Data_b = '0;
    #2 rst_n = 1'b0;
    Valid_a = 1'b1;
    #1;
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_out_data", Out_data, 0);
    chk("rst_ready_a", Ready_a, 0);
    Valid_a = 1'b0;
    Valid_b = 1'b1;
    #1;
    chk("rst_selector", Selector, 0);
    chk("rst_ready_b", Ready_b, 0);
    Valid_b = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Single A operand after reset
    Valid_a = 1'b1; Data_a = 6'h15; Out_ready = 1'b1;
    exp_q.push_back(6'h15);
    @(negedge clk);
    chk("t1_ready_a", Ready_a, 1);
    chk("t1_selector", Selector, 0);
    step();
    Valid_a = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", Out_valid, 1);
    step();
    @(negedge clk);
    chk("t1_out_valid_drop", Out_valid, 0);
    step();

    // Lone B transfer so the round-robin pointer favours A again
    Valid_b = 1'b1; Data_b = 6'h0B;
    exp_q.push_back(6'h0B);
    @(negedge clk);
    chk("t2_ready_b_single", Ready_b, 1);
    step();

    // Both valid continuously: strict alternation A, B, A, B
    Valid_a = 1'b1; Data_a = 6'h01; Data_b = 6'h02;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? 6'h01 : 6'h02);
      @(negedge clk);
      chk($sformatf("t2_selector_%0d", i), Selector, i % 2);
      step();
    end

    // Output stall with both requesters waiting
    Data_a = 6'h2A; Data_b = 6'h15;
    exp_q.push_back(6'h2A);
    @(negedge clk);
    chk("t3_ready_a", Ready_a, 1);
    step();
    Data_a = 6'h2B; Out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_data_%0d", i), Out_data, 6'h2A);
      chk($sformatf("t3_hold_valid_%0d", i), Out_valid, 1);
      chk($sformatf("t3_stall_ready_%0d", i), {Ready_a, Ready_b}, 2'b00);
      chk($sformatf("t3_stall_sel_%0d", i), Selector, 1);
      step();
    end
    Out_ready = 1'b1;
    exp_q.push_back(6'h15);
    exp_q.push_back(6'h2B);
    @(negedge clk);
    chk("t3_release_ready_b", Ready_b, 1);
    step();
    Valid_b = 1'b0;
    @(negedge clk);
    chk("t3_ready_a_after", Ready_a, 1);
    step();
    Valid_a = 1'b0;
    step();

    // Lock behaviour: A transfers with Lock_a held, B waiting
    Valid_a = 1'b1; Data_a = 6'h11; Lock_a = 1'b1;
    exp_q.push_back(6'h11);
    @(negedge clk);
    chk("t4_ready_a0", Ready_a, 1);
    step();
    Data_a = 6'h12; Valid_b = 1'b1; Data_b = 6'h21;
`ifdef ALU_SRC_ARBITER_LOCK_EN
    exp_q.push_back(6'h12);
    @(negedge clk);
    chk("t4_locked_ready_b", Ready_b, 0);
    chk("t4_locked_sel", Selector, 0);
    step();
    Data_a = 6'h13; Lock_a = 1'b0;
    exp_q.push_back(6'h13);
    @(negedge clk);
    chk("t4_last_locked_a", Ready_a, 1);
    step();
    Valid_a = 1'b0;
    exp_q.push_back(6'h21);
    @(negedge clk);
    chk("t4_b_served", Ready_b, 1);
    step();
    Valid_b = 1'b0;
`else
    exp_q.push_back(6'h21);
    @(negedge clk);
    chk("t4_rr_ready_b", Ready_b, 1);
    chk("t4_rr_sel", Selector, 1);
    step();
    Valid_b = 1'b0; Lock_a = 1'b0;
    exp_q.push_back(6'h12);
    @(negedge clk);
    chk("t4_rr_ready_a", Ready_a, 1);
    step();
    Valid_a = 1'b0;
`endif
    step();

    // Lock holder goes idle without lock: B must not deadlock
    Valid_a = 1'b1; Data_a = 6'h31; Lock_a = 1'b1;
    exp_q.push_back(6'h31);
    step();
    Valid_a = 1'b0; Lock_a = 1'b0; Valid_b = 1'b1; Data_b = 6'h32;
    exp_q.push_back(6'h32);
`ifdef ALU_SRC_ARBITER_LOCK_EN
    @(negedge clk);
    chk("t5_locked_ready_b", Ready_b, 0);
    step();
    @(negedge clk);
    chk("t5_unlock_ready_b", Ready_b, 1);
    step();
`else
    @(negedge clk);
    chk("t5_rr_ready_b", Ready_b, 1);
    step();
`endif
    Valid_b = 1'b0;
    step();

    // Asynchronous reset discards a stalled operand
    Valid_a = 1'b1; Data_a = 6'h3F;
    step();
    Valid_a = 1'b0; Out_ready = 1'b0;
    #1;
    chk("t6_pre_data", Out_data, 6'h3F);
    chk("t6_pre_valid", Out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", Out_valid, 0);
    chk("t6_rst_data", Out_data, 0);
    chk("t6_rst_sel", Selector, 0);
    step();
    rst_n = 1'b1; Out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t6_after_valid", Out_valid, 0);
    step();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
